// File: rtl/comparator_pipe.sv
// Two-stage valid/ready comparator: EQ/NE/GT/LT/GE/LE/MIN/MAX, signed or unsigned.
// Define COMPARATOR_PIPE_MATCH_CNT_EN to build the saturating match counter.
module comparator_pipe #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2:0]           Opcode,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     compare_out,
    output logic                 flag,
    input  logic                 clr_count,
    output logic [CNT_WIDTH-1:0] match_count
);

    typedef enum logic [2:0] {
        OP_EQ  = 3'b000,
        OP_NE  = 3'b001,
        OP_GT  = 3'b010,
        OP_LT  = 3'b011,
        OP_GE  = 3'b100,
        OP_LE  = 3'b101,
        OP_MIN = 3'b110,
        OP_MAX = 3'b111
    } op_e;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    op_e              r_s1_op;
    logic             r_s1_signed;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_compare_out;
    logic             r_flag;

    logic             w_s2_adv;
    logic             w_s1_adv;

    assign w_s2_adv = !r_out_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_op     <= OP_EQ;
            r_s1_signed <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_a      <= A;
                r_s1_b      <= B;
                r_s1_op     <= op_e'(Opcode);
                r_s1_signed <= signed_mode;
            end
        end
    end

    // Flipping the sign bit turns a two's-complement order into an unsigned one.
    logic [WIDTH-1:0] w_a_key;
    logic [WIDTH-1:0] w_b_key;
    logic             w_eq;
    logic             w_gt;
    logic             w_lt;
    logic             w_flag;
    logic [WIDTH-1:0] w_res;

    assign w_a_key = {r_s1_a[WIDTH-1] ^ r_s1_signed, r_s1_a[WIDTH-2:0]};
    assign w_b_key = {r_s1_b[WIDTH-1] ^ r_s1_signed, r_s1_b[WIDTH-2:0]};
    assign w_eq    = (r_s1_a == r_s1_b);
    assign w_gt    = (w_a_key > w_b_key);
    assign w_lt    = !w_eq && !w_gt;

    always_comb begin
        w_flag = 1'b0;
        w_res  = '0;
        case (r_s1_op)
            OP_EQ:   w_flag = w_eq;
            OP_NE:   w_flag = !w_eq;
            OP_GT:   w_flag = w_gt;
            OP_LT:   w_flag = w_lt;
            OP_GE:   w_flag = !w_lt;
            OP_LE:   w_flag = !w_gt;
            OP_MIN:  w_flag = !w_gt;
            OP_MAX:  w_flag = !w_lt;
            default: w_flag = 1'b0;
        endcase
        // MIN/MAX return the chosen operand; ties keep A so flag stays 1.
        if (r_s1_op == OP_MIN || r_s1_op == OP_MAX)
            w_res = w_flag ? r_s1_a : r_s1_b;
        else
            w_res = {{(WIDTH-1){1'b0}}, w_flag};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_compare_out <= '0;
            r_flag        <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_compare_out <= w_res;
                r_flag        <= w_flag;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign compare_out = r_compare_out;
    assign flag        = r_flag;

`ifdef COMPARATOR_PIPE_MATCH_CNT_EN
    logic [CNT_WIDTH-1:0] r_match_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_match_count <= '0;
        else if (clr_count)
            r_match_count <= '0;
        else if (r_out_valid && out_ready && r_flag && (r_match_count != {CNT_WIDTH{1'b1}}))
            r_match_count <= r_match_count + CNT_WIDTH'(1);
    end

    assign match_count = r_match_count;
`else
    logic w_unused_clr;

    assign w_unused_clr = clr_count;
    assign match_count  = '0;
`endif

endmodule

// File: tb/tb_comparator_pipe.sv
// Scoreboard bench for comparator_pipe: driver pushes expected results, monitor pops on output handshakes.
module tb_comparator_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic [2:0] Opcode;
    logic       signed_mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] compare_out;
    logic       flag;
    logic       clr_count;
    logic [1:0] match_count;

    int         checks;
    int         errors;
    logic [8:0] exp_q[$];
    logic       saw_in_ready_low;
    logic       prev_stall;
    logic       prev_flag;
    logic [7:0] prev_out;

    comparator_pipe #(.WIDTH(8), .CNT_WIDTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Opcode(Opcode), .signed_mode(signed_mode),
        .out_valid(out_valid), .out_ready(out_ready), .compare_out(compare_out),
        .flag(flag), .clr_count(clr_count), .match_count(match_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op, input logic sm);
        logic signed [8:0] sa;
        logic signed [8:0] sb;
        logic              f;
        logic [7:0]        r;
        sa = sm ? $signed({a[7], a}) : $signed({1'b0, a});
        sb = sm ? $signed({b[7], b}) : $signed({1'b0, b});
        case (op)
            3'd0:    f = (a == b);
            3'd1:    f = (a != b);
            3'd2:    f = (sa > sb);
            3'd3:    f = (sa < sb);
            3'd4:    f = (sa >= sb);
            3'd5:    f = (sa <= sb);
            3'd6:    f = (sa <= sb);
            default: f = (sa >= sb);
        endcase
        r = (op[2] && op[1]) ? (f ? a : b) : {7'd0, f};
        return {f, r};
    endfunction

    // Monitor: pops one expectation per output handshake, checks holds during stalls.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", {23'd0, out_valid, flag, compare_out}, {23'd0, 1'b1, prev_flag, prev_out});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %0h with no expected beat", {flag, compare_out});
                end else begin
                    check("result", {23'd0, flag, compare_out}, {23'd0, exp_q.pop_front()});
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_flag  = flag;
            prev_out   = compare_out;
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic sm, input logic [8:0] e);
        int n;
        n = 0;
        in_valid = 1'b1; A = a; B = b; Opcode = op; signed_mode = sm;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            saw_in_ready_low = 1'b1;
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0, required 1");
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (exp_q.size() != 0 || out_valid) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gaps;
        int bad;
        logic [7:0] ta;
        logic [7:0] tb;
        checks = 0; errors = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_count = 1'b0;
        A = '0; B = '0; Opcode = '0; signed_mode = 1'b0;
        saw_in_ready_low = 1'b0; prev_stall = 1'b0; prev_flag = 1'b0; prev_out = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_compare_out", {24'd0, compare_out}, 0);
        check("rst_flag", {31'd0, flag}, 0);
        check("rst_match_count", {30'd0, match_count}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 1);
        @(posedge clk);
        #1;

        // Latency from acceptance edge: not visible after that edge, visible after the next.
        send(8'hF0, 8'h10, 3'b010, 1'b1, 9'h000);
        @(negedge clk);
        check("latency_s1", {31'd0, out_valid}, 0);
        @(negedge clk);
        check("latency_s2", {31'd0, out_valid}, 1);
        @(posedge clk);
        #1;

        send(8'hF0, 8'h10, 3'b010, 1'b0, 9'h101);
        send(8'h05, 8'hFB, 3'b110, 1'b1, 9'h0FB);
        send(8'h05, 8'hFB, 3'b111, 1'b1, 9'h105);
        send(8'h33, 8'h33, 3'b110, 1'b1, 9'h133);
        send(8'h5A, 8'h5A, 3'b000, 1'b0, 9'h101);
        send(8'h5A, 8'h5A, 3'b001, 1'b1, 9'h000);
        send(8'h01, 8'hFF, 3'b011, 1'b0, 9'h101);
        send(8'h80, 8'h7F, 3'b100, 1'b1, 9'h000);
        send(8'h80, 8'h80, 3'b101, 1'b1, 9'h101);
        send(8'h05, 8'hFB, 3'b111, 1'b0, 9'h0FB);
        send(8'hFF, 8'h01, 3'b011, 1'b1, 9'h101);
        drain();

        // Backpressure: out_ready low for five cycles in the middle of a 10-beat burst.
        saw_in_ready_low = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    ta = 8'(i * 37 + 3);
                    tb = 8'(8'h80 - i * 11);
                    send(ta, tb, 3'(i), i[0], model(ta, tb, 3'(i), i[0]));
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("bp_in_ready_dropped", {31'd0, saw_in_ready_low}, 1);

        // Full rate: 20 beats, consumer always ready.
        saw_in_ready_low = 1'b0;
        gaps = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    ta = 8'(i * 53 + 7);
                    tb = 8'(i * 29 + 200);
                    send(ta, tb, 3'(i + 3), i[1], model(ta, tb, 3'(i + 3), i[1]));
                end
            end
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (!out_valid && n < 10) begin
                    n++;
                    @(negedge clk);
                end
                if (!out_valid) gaps = 100;
                repeat (19) begin
                    @(negedge clk);
                    if (!out_valid) gaps++;
                end
            end
        join
        drain();
        check("full_rate_gaps", gaps, 0);
        check("full_rate_no_stall", {31'd0, saw_in_ready_low}, 0);

        // Asynchronous reset with two beats in flight.
        send(8'h11, 8'h11, 3'b000, 1'b0, 9'h101);
        send(8'h22, 8'h22, 3'b000, 1'b0, 9'h101);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 0);
        check("midrst_compare_out", {24'd0, compare_out}, 0);
        check("midrst_flag", {31'd0, flag}, 0);
        check("midrst_match_count", {30'd0, match_count}, 0);
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        check("midrst_no_stale", bad, 0);
        check("midrst_in_ready", {31'd0, in_ready}, 1);
        @(posedge clk);
        #1;

`ifdef COMPARATOR_PIPE_MATCH_CNT_EN
        for (int i = 0; i < 5; i++)
            send(8'(i), 8'(i), 3'b000, 1'b0, {1'b1, 8'h01});
        drain();
        check("cnt_saturate", {30'd0, match_count}, 3);
        out_ready = 1'b0;
        send(8'h77, 8'h77, 3'b000, 1'b0, 9'h101);
        @(negedge clk);
        @(negedge clk);
        check("cnt_hold_stall", {30'd0, match_count}, 3);
        @(posedge clk);
        #1 clr_count = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 clr_count = 1'b0;
        check("cnt_clear_wins", {30'd0, match_count}, 0);
        drain();
`else
        for (int i = 0; i < 3; i++)
            send(8'(i), 8'(i), 3'b000, 1'b0, {1'b1, 8'h01});
        drain();
        check("cnt_disabled_zero", {30'd0, match_count}, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
